unified_mem_arbiter: RTL and testbench

- Shares one single-port, fixed-latency memory between the IF stage (instruction fetch) and the MEM stage (data load/store) of the 5-stage pipeline.
- Sequences each access over MEM_LAT cycles and returns read data to the requester.
- Drives a pipeline-wide stall while any request is outstanding.
- Data requests have priority; a starvation counter guarantees fetch progress.

---
 rtl/unified_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_unified_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and data access,
// with data priority, a fetch starvation guard and a pipeline stall. Optional perf counters: ARB_PERF_CNT_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 3,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_valid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic              dm_gnt_o,
  output logic              dm_valid_o,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_stall_cycles_o,
  output logic [15:0]       perf_conflict_o
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  localparam logic [3:0] LAST_CNT   = 4'(MEM_LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t            state;
  logic [3:0]        lat_cnt;
  logic [3:0]        starve_cnt;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_we;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] dm_rdata_q;
  logic              busy;
  logic              done;
  logic              grant_dm;
  logic              grant_if;

  // Data wins unless fetch has already been passed over STARVE_MAX times in a row.
  always_comb begin
    busy     = (state != IDLE);
    done     = busy && (lat_cnt == LAST_CNT);
    grant_dm = dm_req_i && ((starve_cnt < STARVE_LIM) || !if_req_i);
    grant_if = !grant_dm && if_req_i;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      lat_cnt    <= '0;
      starve_cnt <= '0;
      cmd_addr   <= '0;
      cmd_we     <= 1'b0;
      cmd_wdata  <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          lat_cnt <= '0;
          if (grant_dm) begin
            state     <= BUSY_DM;
            cmd_addr  <= dm_addr_i;
            cmd_we    <= dm_we_i;
            cmd_wdata <= dm_wdata_i;
            if (!if_req_i)
              starve_cnt <= '0;
            else if (starve_cnt < STARVE_LIM)
              starve_cnt <= starve_cnt + 4'd1;
          end else if (grant_if) begin
            state      <= BUSY_IF;
            cmd_addr   <= if_addr_i;
            cmd_we     <= 1'b0;
            starve_cnt <= '0;
          end else begin
            starve_cnt <= '0;
          end
        end
        BUSY_IF, BUSY_DM: begin
          if (done) begin
            state   <= IDLE;
            lat_cnt <= '0;
            if (state == BUSY_IF)
              if_rdata_q <= mem_rdata_i;
            else if (!cmd_we)
              dm_rdata_q <= mem_rdata_i;
          end else begin
            lat_cnt <= lat_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data is forwarded in the completion cycle itself, then held from the register.
  assign if_gnt_o    = (state == BUSY_IF);
  assign dm_gnt_o    = (state == BUSY_DM);
  assign if_valid_o  = (state == BUSY_IF) && done;
  assign dm_valid_o  = (state == BUSY_DM) && done;
  assign if_rdata_o  = if_valid_o ? mem_rdata_i : if_rdata_q;
  assign dm_rdata_o  = (dm_valid_o && !cmd_we) ? mem_rdata_i : dm_rdata_q;
  assign mem_en_o    = busy;
  assign mem_we_o    = (state == BUSY_DM) && cmd_we;
  assign mem_addr_o  = cmd_addr;
  assign mem_wdata_o = cmd_wdata;
  assign stall_o     = (if_req_i && !if_valid_o) || (dm_req_i && !dm_valid_o);

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_stall_cycles_o <= '0;
      perf_conflict_o     <= '0;
    end else begin
      if (stall_o && (perf_stall_cycles_o != 32'hFFFF_FFFF))
        perf_stall_cycles_o <= perf_stall_cycles_o + 32'd1;
      if ((state == IDLE) && if_req_i && dm_req_i && (perf_conflict_o != 16'hFFFF))
        perf_conflict_o <= perf_conflict_o + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: a MEM_LAT=3 instance for most scenarios and a
// MEM_LAT=1 instance for the single-cycle access case.
module tb_unified_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i = 1'b0;
  logic [31:0] if_addr_i = '0;
  logic        if_gnt_o, if_valid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i = 1'b0;
  logic        dm_we_i = 1'b0;
  logic [31:0] dm_addr_i = '0;
  logic [31:0] dm_wdata_i = '0;
  logic        dm_gnt_o, dm_valid_o;
  logic [31:0] dm_rdata_o;
  logic        mem_en_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [31:0] mem_rdata_i = '0;
  logic        stall_o;

  logic        l_if_req = 1'b0;
  logic [31:0] l_if_addr = '0;
  logic        l_if_gnt, l_if_valid;
  logic [31:0] l_if_rdata;
  logic        l_dm_req = 1'b0;
  logic        l_dm_we = 1'b0;
  logic [31:0] l_dm_addr = '0;
  logic [31:0] l_dm_wdata = '0;
  logic        l_dm_gnt, l_dm_valid;
  logic [31:0] l_dm_rdata;
  logic        l_mem_en, l_mem_we;
  logic [31:0] l_mem_addr, l_mem_wdata;
  logic [31:0] l_mem_rdata = '0;
  logic        l_stall;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_stall, l_perf_stall;
  logic [15:0] perf_conflict, l_perf_conflict;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .STARVE_MAX(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_valid_o(if_valid_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_gnt_o(dm_gnt_o), .dm_valid_o(dm_valid_o), .dm_rdata_o(dm_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
`ifdef ARB_PERF_CNT_EN
    , .perf_stall_cycles_o(perf_stall), .perf_conflict_o(perf_conflict)
`endif
  );

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(l_if_req), .if_addr_i(l_if_addr), .if_gnt_o(l_if_gnt),
    .if_valid_o(l_if_valid), .if_rdata_o(l_if_rdata),
    .dm_req_i(l_dm_req), .dm_we_i(l_dm_we), .dm_addr_i(l_dm_addr), .dm_wdata_i(l_dm_wdata),
    .dm_gnt_o(l_dm_gnt), .dm_valid_o(l_dm_valid), .dm_rdata_o(l_dm_rdata),
    .mem_en_o(l_mem_en), .mem_we_o(l_mem_we), .mem_addr_o(l_mem_addr),
    .mem_wdata_o(l_mem_wdata), .mem_rdata_i(l_mem_rdata), .stall_o(l_stall)
`ifdef ARB_PERF_CNT_EN
    , .perf_stall_cycles_o(l_perf_stall), .perf_conflict_o(l_perf_conflict)
`endif
  );

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0;
    tick();
    tick();
    #1;
    checks++; if ({if_gnt_o, if_valid_o, dm_gnt_o, dm_valid_o, mem_en_o, mem_we_o, stall_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl got %b want 0000000", {if_gnt_o, if_valid_o, dm_gnt_o, dm_valid_o, mem_en_o, mem_we_o, stall_o});
    end
    checks++; if ({mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o} !== 128'h0) begin
      errors++; $display("FAIL reset_data got %h want 0", {mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o});
    end
    rst_i = 1'b1;
  endtask

  task automatic test_if_fetch();
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0010; mem_rdata_i = 32'hDEAD_BEEF;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) tick();
      if (c == 4) begin if_req_i = 1'b0; mem_rdata_i = 32'h0; end
      #1;
      checks++; if (if_gnt_o !== (c >= 1 && c <= 3)) begin
        errors++; $display("FAIL if_gnt c%0d got %b want %b", c, if_gnt_o, (c >= 1 && c <= 3));
      end
      checks++; if (if_valid_o !== (c == 3)) begin
        errors++; $display("FAIL if_valid c%0d got %b want %b", c, if_valid_o, (c == 3));
      end
      checks++; if (stall_o !== (c <= 2)) begin
        errors++; $display("FAIL if_stall c%0d got %b want %b", c, stall_o, (c <= 2));
      end
      if (c == 2) begin
        checks++; if ({mem_en_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h0000_0010}) begin
          errors++; $display("FAIL if_mem_cmd got %b%b %h want 10 00000010", mem_en_o, mem_we_o, mem_addr_o);
        end
      end
      if (c >= 3) begin
        checks++; if (if_rdata_o !== 32'hDEAD_BEEF) begin
          errors++; $display("FAIL if_rdata c%0d got %h want deadbeef", c, if_rdata_o);
        end
      end
    end
  endtask

  task automatic test_conflict();
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0040;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0100;
    mem_rdata_i = 32'hCAFE_0001;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) tick();
      if (c == 4) begin dm_req_i = 1'b0; mem_rdata_i = 32'h0BAD_F00D; end
      if (c == 8) if_req_i = 1'b0;
      #1;
      checks++; if ({dm_gnt_o, dm_valid_o} !== {(c >= 1 && c <= 3), (c == 3)}) begin
        errors++; $display("FAIL conf_dm c%0d got %b%b want %b%b", c, dm_gnt_o, dm_valid_o, (c >= 1 && c <= 3), (c == 3));
      end
      checks++; if ({if_gnt_o, if_valid_o} !== {(c >= 5 && c <= 7), (c == 7)}) begin
        errors++; $display("FAIL conf_if c%0d got %b%b want %b%b", c, if_gnt_o, if_valid_o, (c >= 5 && c <= 7), (c == 7));
      end
      checks++; if (stall_o !== (c <= 6)) begin
        errors++; $display("FAIL conf_stall c%0d got %b want %b", c, stall_o, (c <= 6));
      end
      if (c == 2 || c == 6) begin
        checks++; if (mem_addr_o !== ((c == 2) ? 32'h100 : 32'h40)) begin
          errors++; $display("FAIL conf_addr c%0d got %h want %h", c, mem_addr_o, ((c == 2) ? 32'h100 : 32'h40));
        end
      end
      if (c == 8) begin
        checks++; if ({dm_rdata_o, if_rdata_o} !== {32'hCAFE_0001, 32'h0BAD_F00D}) begin
          errors++; $display("FAIL conf_rdata got %h %h want cafe0001 0badf00d", dm_rdata_o, if_rdata_o);
        end
      end
    end
  endtask

  task automatic test_store();
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h0000_0200; dm_wdata_i = 32'h1234_5678;
    mem_rdata_i = 32'hFFFF_FFFF;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      if (c == 4) begin dm_req_i = 1'b0; dm_we_i = 1'b0; end
      #1;
      if (c >= 1 && c <= 3) begin
        checks++; if ({mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o} !== {2'b11, 32'h200, 32'h1234_5678}) begin
          errors++; $display("FAIL st_cmd c%0d got %b%b %h %h want 11 00000200 12345678", c, mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o);
        end
      end
      checks++; if (dm_valid_o !== (c == 3)) begin
        errors++; $display("FAIL st_valid c%0d got %b want %b", c, dm_valid_o, (c == 3));
      end
      checks++; if (dm_rdata_o !== 32'hCAFE_0001) begin
        errors++; $display("FAIL st_rdata c%0d got %h want cafe0001", c, dm_rdata_o);
      end
    end
  endtask

  task automatic test_starvation();
    int   dm_done   = 0;
    int   if_gnt_cy = -1;
    logic if_done   = 1'b0;
    logic prev_if_v = 1'b0;
    logic prev_dm_v = 1'b0;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h0000_0080;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0300;
    mem_rdata_i = 32'h1111_2222;
    for (int c = 0; c < 60; c++) begin
      if (c > 0) tick();
      if (prev_if_v) if_req_i = 1'b0;
      if (prev_dm_v && if_done) dm_req_i = 1'b0;
      #1;
      if (dm_valid_o && if_gnt_cy < 0) dm_done++;
      if (if_gnt_o && if_gnt_cy < 0) if_gnt_cy = c;
      if (if_valid_o) if_done = 1'b1;
      if (c == 21) begin
        checks++; if (dm_gnt_o !== 1'b1) begin
          errors++; $display("FAIL starve_dm_after_if got %b want 1", dm_gnt_o);
        end
      end
      prev_if_v = if_valid_o;
      prev_dm_v = dm_valid_o;
      if (!if_req_i && !dm_req_i && !dm_gnt_o && !if_gnt_o) break;
    end
    checks++; if (dm_done !== 4) begin
      errors++; $display("FAIL starve_dm_count got %0d want 4", dm_done);
    end
    checks++; if (if_gnt_cy !== 17) begin
      errors++; $display("FAIL starve_if_gnt_cycle got %0d want 17", if_gnt_cy);
    end
    checks++; if (if_done !== 1'b1) begin
      errors++; $display("FAIL starve_timeout if_done got %b want 1", if_done);
    end
    if_req_i = 1'b0; dm_req_i = 1'b0;
  endtask

  task automatic test_async_reset();
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h0000_0400; mem_rdata_i = 32'h5555_AAAA;
    tick();
    tick();
    checks++; if (dm_gnt_o !== 1'b1) begin
      errors++; $display("FAIL ar_pre_gnt got %b want 1", dm_gnt_o);
    end
    rst_i = 1'b0;
    #1;
    checks++; if ({mem_en_o, dm_gnt_o, dm_valid_o} !== 3'b000) begin
      errors++; $display("FAIL ar_ctrl got %b want 000", {mem_en_o, dm_gnt_o, dm_valid_o});
    end
    checks++; if ({dm_rdata_o, if_rdata_o} !== 64'h0) begin
      errors++; $display("FAIL ar_rdata got %h %h want 0 0", dm_rdata_o, if_rdata_o);
    end
    tick();
    tick();
    rst_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      if (c == 4) dm_req_i = 1'b0;
      #1;
      checks++; if ({dm_gnt_o, dm_valid_o} !== {(c >= 1 && c <= 3), (c == 3)}) begin
        errors++; $display("FAIL ar_regrant c%0d got %b%b want %b%b", c, dm_gnt_o, dm_valid_o, (c >= 1 && c <= 3), (c == 3));
      end
      if (c == 3) begin
        checks++; if (dm_rdata_o !== 32'h5555_AAAA) begin
          errors++; $display("FAIL ar_rdata_after got %h want 5555aaaa", dm_rdata_o);
        end
      end
    end
  endtask

  task automatic test_lat1();
    tick();
    l_if_req = 1'b1; l_if_addr = 32'h20;
    l_dm_req = 1'b1; l_dm_we = 1'b0; l_dm_addr = 32'h24;
    l_mem_rdata = 32'h7777_0001;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) tick();
      if (c == 2) l_dm_req = 1'b0;
      if (c == 4) begin l_if_req = 1'b0; l_dm_req = 1'b1; l_dm_addr = 32'h28; end
      if (c == 6) l_dm_req = 1'b0;
      #1;
      checks++; if ({l_dm_gnt, l_dm_valid} !== {2{(c == 1 || c == 5)}}) begin
        errors++; $display("FAIL l1_dm c%0d got %b%b want %b%b", c, l_dm_gnt, l_dm_valid, (c == 1 || c == 5), (c == 1 || c == 5));
      end
      checks++; if ({l_if_gnt, l_if_valid} !== {2{(c == 3)}}) begin
        errors++; $display("FAIL l1_if c%0d got %b%b want %b%b", c, l_if_gnt, l_if_valid, (c == 3), (c == 3));
      end
      if (c == 5) begin
        checks++; if ({l_mem_en, l_mem_addr, l_if_rdata, l_dm_rdata} !== {1'b1, 32'h28, 32'h7777_0001, 32'h7777_0001}) begin
          errors++; $display("FAIL l1_data got %b %h %h %h want 1 00000028 77770001 77770001", l_mem_en, l_mem_addr, l_if_rdata, l_dm_rdata);
        end
      end
    end
`ifdef ARB_PERF_CNT_EN
    checks++; if (l_perf_conflict !== 16'd1) begin
      errors++; $display("FAIL l1_perf_conflict got %0d want 1", l_perf_conflict);
    end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_if_fetch();
    test_conflict();
    test_store();
    test_starvation();
    test_async_reset();
    test_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
